// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle execute ALU.
package alu_mc_pkg;

   localparam logic [3:0] OpAdd = 4'd0;
   localparam logic [3:0] OpSub = 4'd1;
   localparam logic [3:0] OpMul = 4'd2;
   localparam logic [3:0] OpOr  = 4'd3;
   localparam logic [3:0] OpAnd = 4'd4;
   localparam logic [3:0] OpLdb = 4'd5;
   localparam logic [3:0] OpLdw = 4'd6;
   localparam logic [3:0] OpStb = 4'd7;
   localparam logic [3:0] OpStw = 4'd8;
   localparam logic [3:0] OpMov = 4'd9;
   localparam logic [3:0] OpDiv = 4'd10;
   localparam logic [3:0] OpRem = 4'd11;

   typedef enum logic [1:0] {
      StIdle,
      StMulBusy,
      StDivBusy,
      StDone
   } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
// After completion hi/lo hold {product high, product low} or {remainder, quotient}.
module alu_mc_iter import alu_mc_pkg::*; #(
   parameter int unsigned DATA_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 kill,
   input  logic                 start,
   input  logic                 mode,   // 0: multiply, 1: divide
   input  logic [DATA_SIZE-1:0] a,
   input  logic [DATA_SIZE-1:0] b,
   output logic                 done,
   output logic [DATA_SIZE-1:0] hi,
   output logic [DATA_SIZE-1:0] lo
);

   localparam int unsigned CntW = $clog2(DATA_SIZE);

   logic [DATA_SIZE-1:0] acc_q, acc_d;
   logic [DATA_SIZE-1:0] sh_q, sh_d;
   logic [DATA_SIZE-1:0] opb_q, opb_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [DATA_SIZE:0]   sum;
   logic [DATA_SIZE:0]   trial;

   assign sum   = {1'b0, acc_q} + {1'b0, opb_q};
   // Remainder stays below the divisor, so the MSB of trial is a clean borrow flag.
   assign trial = {acc_q, sh_q[DATA_SIZE-1]} - {1'b0, opb_q};

   // Next-state: load on start, otherwise one multiply or divide step per busy cycle.
   always_comb begin
      acc_d  = acc_q;
      sh_d   = sh_q;
      opb_d  = opb_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (kill) begin
         busy_d = 1'b0;
      end else if (start) begin
         acc_d  = '0;
         sh_d   = a;
         opb_d  = b;
         cnt_d  = CntW'(DATA_SIZE - 1);
         mode_d = mode;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (!mode_q) begin
            if (sh_q[0]) begin
               {acc_d, sh_d} = {sum, sh_q[DATA_SIZE-1:1]};
            end else begin
               {acc_d, sh_d} = {1'b0, acc_q, sh_q[DATA_SIZE-1:1]};
            end
         end else begin
            if (!trial[DATA_SIZE]) begin
               acc_d = trial[DATA_SIZE-1:0];
               sh_d  = {sh_q[DATA_SIZE-2:0], 1'b1};
            end else begin
               acc_d = {acc_q[DATA_SIZE-2:0], sh_q[DATA_SIZE-1]};
               sh_d  = {sh_q[DATA_SIZE-2:0], 1'b0};
            end
         end
         if (cnt_q == '0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CntW'(1);
         end
      end
   end

   // Iteration state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         sh_q   <= '0;
         opb_q  <= '0;
         cnt_q  <= '0;
         mode_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         sh_q   <= sh_d;
         opb_q  <= opb_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;
   assign hi   = acc_q;
   assign lo   = sh_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle ops, iterative MUL/DIV/REM, valid/ready handshakes.
module alu_mc import alu_mc_pkg::*; #(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned OP_WIDTH  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OP_WIDTH-1:0]  op,
   input  logic [DATA_SIZE-1:0] da,
   input  logic [DATA_SIZE-1:0] db,
   input  logic [DATA_SIZE-1:0] inm,
   input  logic                 kill,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_SIZE-1:0] dout,
   output logic [DATA_SIZE-1:0] dout_hi,
   output logic                 zero,
   output logic                 ovf,
   output logic                 div0
);

   localparam int unsigned Msb = DATA_SIZE - 1;

   state_e               state_q, state_d;
   logic                 pend_q, pend_d;  // single-cycle result captured, DONE next cycle
   logic                 swap_q, swap_d;  // REM: remainder goes to dout
   logic [DATA_SIZE-1:0] dout_q, dout_d;
   logic [DATA_SIZE-1:0] dout_hi_q, dout_hi_d;
   logic                 zero_q, zero_d;
   logic                 ovf_q, ovf_d;
   logic                 div0_q, div0_d;

   logic                 is_mul, is_div, is_rem, db_zero, iter_start;
   logic                 iter_done;
   logic [DATA_SIZE-1:0] iter_hi, iter_lo;
   logic [DATA_SIZE-1:0] add_res, sub_res, neg_db;
   logic [DATA_SIZE-1:0] sc_res, sc_hi;
   logic                 sc_ovf, sc_div0;

   assign is_mul  = (op == OP_WIDTH'(OpMul));
   assign is_rem  = (op == OP_WIDTH'(OpRem));
   assign is_div  = (op == OP_WIDTH'(OpDiv)) || is_rem;
   assign db_zero = (db == '0);

   assign iter_start = (state_q == StIdle) && !pend_q && in_valid && !kill &&
                       (is_mul || (is_div && !db_zero));

   assign add_res = da + db;
   assign neg_db  = ~db + DATA_SIZE'(1);
   assign sub_res = da + neg_db;

   // Single-cycle result mux, including the divide-by-zero shortcut.
   always_comb begin
      sc_res  = db;
      sc_hi   = '0;
      sc_ovf  = 1'b0;
      sc_div0 = 1'b0;
      case (op)
         OP_WIDTH'(OpAdd): begin
            sc_res = add_res;
            sc_ovf = (da[Msb] == db[Msb]) && (add_res[Msb] != da[Msb]);
         end
         OP_WIDTH'(OpSub): begin
            sc_res = sub_res;
            sc_ovf = (da[Msb] == neg_db[Msb]) && (sub_res[Msb] != da[Msb]);
         end
         OP_WIDTH'(OpOr):  sc_res = da | db;
         OP_WIDTH'(OpAnd): sc_res = da & db;
         OP_WIDTH'(OpLdb), OP_WIDTH'(OpLdw): sc_res = da + inm;
         OP_WIDTH'(OpStb), OP_WIDTH'(OpStw): sc_res = db + inm;
         OP_WIDTH'(OpMov): sc_res = da;
         OP_WIDTH'(OpDiv): begin
            sc_res  = '1;
            sc_hi   = da;
            sc_div0 = 1'b1;
         end
         OP_WIDTH'(OpRem): begin
            sc_res  = da;
            sc_hi   = '1;
            sc_div0 = 1'b1;
         end
         default: sc_res = db;
      endcase
   end

   // FSM next-state and result capture; kill overrides every transition.
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      swap_d    = swap_q;
      dout_d    = dout_q;
      dout_hi_d = dout_hi_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      div0_d    = div0_q;
      if (kill) begin
         state_d = StIdle;
         pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pend_q) begin
                  state_d = StDone;
                  pend_d  = 1'b0;
               end else if (in_valid) begin
                  if (is_mul) begin
                     state_d = StMulBusy;
                     swap_d  = 1'b0;
                  end else if (is_div && !db_zero) begin
                     state_d = StDivBusy;
                     swap_d  = is_rem;
                  end else begin
                     pend_d    = 1'b1;
                     dout_d    = sc_res;
                     dout_hi_d = sc_hi;
                     ovf_d     = sc_ovf;
                     div0_d    = sc_div0;
                     zero_d    = (sc_res == '0);
                  end
               end
            end
            StMulBusy, StDivBusy: begin
               if (iter_done) begin
                  state_d   = StDone;
                  dout_d    = swap_q ? iter_hi : iter_lo;
                  dout_hi_d = swap_q ? iter_lo : iter_hi;
                  ovf_d     = 1'b0;
                  div0_d    = 1'b0;
                  zero_d    = (dout_d == '0);
               end
            end
            StDone: begin
               if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Control and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         pend_q    <= 1'b0;
         swap_q    <= 1'b0;
         dout_q    <= '0;
         dout_hi_q <= '0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         swap_q    <= swap_d;
         dout_q    <= dout_d;
         dout_hi_q <= dout_hi_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
         div0_q    <= div0_d;
      end
   end

   alu_mc_iter #(
      .DATA_SIZE (DATA_SIZE)
   ) u_iter (
      .clk   (clk),
      .reset (reset),
      .kill  (kill),
      .start (iter_start),
      .mode  (is_div),
      .a     (da),
      .b     (db),
      .done  (iter_done),
      .hi    (iter_hi),
      .lo    (iter_lo)
   );

   assign in_ready  = (state_q == StIdle) && !pend_q;
   assign out_valid = (state_q == StDone);
   assign dout      = dout_q;
   assign dout_hi   = dout_hi_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign div0      = div0_q;

endmodule
